oled_frame_scheduler: RTL and testbench
=======================================

OLED_FRAME_SCHEDULER -- requirements
Module: oled_frame_scheduler

Interface
REQ-001 Parameter NUM_SRC, default 4: number of pixel-source requesters, legal range 2..8.
REQ-002 Parameter DWELL_FRAMES, default 8: minimum frames a granted source holds the display while others wait, legal range 1..255.
REQ-003 Parameter BG_COLOR, default 16'h0000: RGB565 value driven when no source is granted.
REQ-004 CLK  input  1: single clock, the 6.25 MHz OLED pixel clock domain; all logic rises on posedge CLK.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 frame_begin  input  1: one-cycle pulse from the OLED driver marking the start of a frame.
REQ-007 req  input  NUM_SRC: per-source display request, level-sensitive.
REQ-008 src_data  input  16*NUM_SRC: RGB565 pixel from each source; source i occupies bits [16*i+15:16*i].
REQ-009 pixel_data  output  16: registered pixel to the OLED driver.
REQ-010 grant  output  NUM_SRC: one-hot active source, or all-zero when idle.
REQ-011 active_idx  output  3: binary index of the granted source, 0 when idle.
REQ-012 switch_pulse  output  1: one-cycle pulse on every grant change, including entry to and exit from idle.

Function
REQ-013 State machine, two states:
  - IDLE: grant=0.
  - ACTIVE: exactly one grant bit set.
REQ-014 Grant decisions occur only on cycles with frame_begin=1; between pulses, grant, active_idx and state are frozen regardless of req.
REQ-015 IDLE -> ACTIVE on frame_begin with any req bit set; the winner is the lowest set index at or above rr_ptr, wrapping.
REQ-016 ACTIVE, frame_begin, owner req=0: rotate to the next requester after the owner (round-robin, wrapping); go to IDLE if none.
REQ-017 ACTIVE, frame_begin, owner req=1:
  - dwell_cnt < DWELL_FRAMES-1: increment dwell_cnt and keep the owner.
  - Otherwise, with another req bit set: grant the next requester after the owner.
  - Otherwise: keep the owner and saturate dwell_cnt.
REQ-018 dwell_cnt is 8 bits and clears to 0 on every grant change.
REQ-019 rr_ptr (3 bits) is loaded with (new owner index + 1) mod NUM_SRC on each grant; it is used only for the IDLE->ACTIVE search.
REQ-020 switch_pulse is asserted in the cycle after the frame_begin that changed the grant, for exactly one cycle.
REQ-021 pixel_data timing:
  - pixel_data <= src_data[active source] every cycle, or BG_COLOR when IDLE.
  - Latency is one cycle from src_data to pixel_data.
  - The new grant's pixel appears on the cycle after the switching frame_begin.
REQ-022 A frame_begin that arrives together with a req change uses the req value sampled in that same cycle.
REQ-023 Back-to-back frame_begin pulses on consecutive cycles are each treated as a separate decision point.
REQ-024 The datapath is fully synchronous to CLK with no combinational path from req to grant; implementation is 120-400 lines.

Reset
REQ-025 While reset=1, immediately and asynchronously:
  - state=IDLE, grant=0, active_idx=0.
  - dwell_cnt=0, rr_ptr=0.
  - switch_pulse=0, pixel_data=BG_COLOR.
REQ-026 Reset asserted mid-frame aborts the current grant. The first decision after release occurs at the next frame_begin; no decision is made on the release cycle itself.

Verification
REQ-027 Single requester: req=4'b0100, one frame_begin -> next cycle grant=4'b0100, active_idx=2, switch_pulse=1 for one cycle, and pixel_data equals src_data[47:32] one cycle after each change.
REQ-028 Dwell and round-robin: DWELL_FRAMES=3, req=4'b1011 held, owner 0:
  - frame_begin 1 and 2 keep owner 0.
  - frame_begin 3 grants source 1; three frames later source 3; three frames later source 0.
REQ-029 Owner drop: owner 1 with dwell_cnt=1, req falls to 4'b0001 mid-frame -> grant holds until the next frame_begin, then grant=4'b0001 and dwell_cnt=0.
REQ-030 Empty: owner drops and req=0 at frame_begin -> IDLE, grant=0, pixel_data=BG_COLOR next cycle, switch_pulse=1.
REQ-031 Reset: assert reset while ACTIVE between frames -> grant=0 and pixel_data=BG_COLOR without waiting for a clock edge. After release with req=4'b1000 -> no grant until the next frame_begin, then grant=4'b1000.
REQ-032 Req toggling without frame_begin: req pulses for 100 cycles with no frame_begin -> grant, active_idx and switch_pulse stay unchanged.

Source files
------------

// File: rtl/oled_frame_scheduler_if.sv
// Bus between the OLED pixel sources/driver and the frame scheduler.
// The scheduler side uses the slave modport; stimulus or the source fabric uses master.
interface oled_frame_scheduler_if #(
    parameter int NUM_SRC = 4
);
    logic                    frame_begin;
    logic [NUM_SRC-1:0]      req;
    logic [16*NUM_SRC-1:0]   src_data;
    logic [15:0]             pixel_data;
    logic [NUM_SRC-1:0]      grant;
    logic [2:0]              active_idx;
    logic                    switch_pulse;

    modport master (
        output frame_begin, req, src_data,
        input  pixel_data, grant, active_idx, switch_pulse
    );

    modport slave (
        input  frame_begin, req, src_data,
        output pixel_data, grant, active_idx, switch_pulse
    );
endinterface

// File: rtl/oled_frame_scheduler.sv
// Frame-synchronous round-robin arbiter that picks which pixel source drives the OLED,
// holding each owner for a minimum dwell of frames while others are waiting.
module oled_frame_scheduler #(
    parameter int          NUM_SRC      = 4,
    parameter int          DWELL_FRAMES = 8,
    parameter logic [15:0] BG_COLOR     = 16'h0000
) (
    input  logic                   CLK,
    input  logic                   reset,
    oled_frame_scheduler_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL_FRAMES - 1);

    state_t               state_q, state_d;
    logic [2:0]           owner_q, owner_d;
    logic [2:0]           rr_q, rr_d;
    logic [7:0]           dwell_q, dwell_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic                 switch_q, switch_d;
    logic [15:0]          pixel_q, pixel_d;
    logic                 owner_req_s;
    logic [3:0]           idle_pick_s;
    logic [3:0]           rot_pick_s;

    // Returns {found, index} of the first set request at offset 0 (or 1 when
    // skip_base) and upward from base, wrapping modulo NUM_SRC.
    function automatic logic [3:0] pick_next(input logic [NUM_SRC-1:0] r,
                                             input logic [2:0]         base,
                                             input logic               skip_base);
        logic [3:0] res;
        int         idx;
        res = 4'b0000;
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            idx = (int'(base) + off) % NUM_SRC;
            for (int j = 0; j < NUM_SRC; j++) begin
                if ((j == idx) && r[j] && ((off != 0) || !skip_base)) begin
                    res = {1'b1, 3'(j)};
                end else begin
                    res = res;
                end
            end
        end
        return res;
    endfunction

    // Next-state decision: grant only moves on frame_begin, everything else holds.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        dwell_d  = dwell_q;
        switch_d = 1'b0;

        owner_req_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (3'(i) == owner_q) begin
                owner_req_s = bus.req[i];
            end else begin
                owner_req_s = owner_req_s;
            end
        end
        idle_pick_s = pick_next(bus.req, rr_q, 1'b0);
        rot_pick_s  = pick_next(bus.req, owner_q, 1'b1);

        if (bus.frame_begin) begin
            case (state_q)
                ST_IDLE: begin
                    if (idle_pick_s[3]) begin
                        state_d  = ST_ACTIVE;
                        owner_d  = idle_pick_s[2:0];
                        rr_d     = 3'((int'(idle_pick_s[2:0]) + 1) % NUM_SRC);
                        dwell_d  = 8'd0;
                        switch_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (!owner_req_s || ((dwell_q >= DWELL_LAST) && rot_pick_s[3])) begin
                        // Owner released, or dwell served with someone waiting.
                        if (rot_pick_s[3]) begin
                            owner_d  = rot_pick_s[2:0];
                            rr_d     = 3'((int'(rot_pick_s[2:0]) + 1) % NUM_SRC);
                        end else begin
                            state_d  = ST_IDLE;
                            owner_d  = 3'd0;
                        end
                        dwell_d  = 8'd0;
                        switch_d = 1'b1;
                    end else if (dwell_q < DWELL_LAST) begin
                        dwell_d = dwell_q + 8'd1;
                    end else begin
                        dwell_d = dwell_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    owner_d = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        grant_d = '0;
        pixel_d = BG_COLOR;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((state_d == ST_ACTIVE) && (3'(i) == owner_d)) begin
                grant_d[i] = 1'b1;
                pixel_d    = bus.src_data[16*i +: 16];
            end else begin
                grant_d[i] = 1'b0;
            end
        end
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= 3'd0;
            rr_q     <= 3'd0;
            dwell_q  <= 8'd0;
            grant_q  <= '0;
            switch_q <= 1'b0;
            pixel_q  <= BG_COLOR;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            dwell_q  <= dwell_d;
            grant_q  <= grant_d;
            switch_q <= switch_d;
            pixel_q  <= pixel_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.active_idx   = owner_q;
    assign bus.switch_pulse = switch_q;
    assign bus.pixel_data   = pixel_q;
endmodule

// File: tb/tb_oled_frame_scheduler.sv
// Bench for oled_frame_scheduler: directed vector table, reset/idle-req corner
// sequences, then random traffic against a frame-level reference model.
module tb_oled_frame_scheduler;
    localparam int          N     = 4;
    localparam int          DWELL = 3;
    localparam logic [15:0] BG    = 16'hF81F;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    oled_frame_scheduler_if #(.NUM_SRC(N)) bus ();

    oled_frame_scheduler #(
        .NUM_SRC      (N),
        .DWELL_FRAMES (DWELL),
        .BG_COLOR     (BG)
    ) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner as an integer (-1 = idle) and frame counters.
    int          m_owner;
    int          m_dwell;
    int          m_rr;
    logic        m_sw;
    logic [15:0] m_pix;

    function automatic int first_req(input int from, input logic [3:0] r, input int first_off);
        for (int k = first_off; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_dwell = 0;
        m_rr    = 0;
        m_sw    = 1'b0;
        m_pix   = BG;
    endtask

    task automatic model_step(input logic fb, input logic [3:0] r, input logic [63:0] s);
        int nxt;
        int cand;
        nxt = m_owner;
        if (fb) begin
            if (m_owner < 0) begin
                if (r != 4'd0) nxt = first_req(m_rr, r, 0);
            end else if (!r[m_owner]) begin
                nxt = first_req(m_owner, r, 1);
            end else if (m_dwell < DWELL - 1) begin
                m_dwell = m_dwell + 1;
            end else begin
                cand = first_req(m_owner, r, 1);
                if (cand >= 0) nxt = cand;
            end
        end
        m_sw = (nxt != m_owner);
        if (m_sw) begin
            m_dwell = 0;
            if (nxt >= 0) m_rr = (nxt + 1) % N;
        end
        m_owner = nxt;
        m_pix   = (m_owner < 0) ? BG : s[16*m_owner +: 16];
    endtask

    function automatic logic [3:0] m_grant();
        return (m_owner < 0) ? 4'd0 : (4'd1 << m_owner);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at a falling edge, advance the model, return at the next falling edge.
    task automatic apply(input logic fb, input logic [3:0] r, input logic [63:0] s);
        bus.frame_begin = fb;
        bus.req         = r;
        bus.src_data    = s;
        model_step(fb, r, s);
        @(negedge clk);
    endtask

    typedef struct {
        logic       fb;
        logic [3:0] req;
        logic [3:0] g;
        logic [2:0] idx;
        logic       sw;
    } vec_t;

    vec_t        tbl [26];
    logic [63:0] src_const;
    logic [15:0] exp_pix;
    logic [3:0]  held_grant;
    logic [2:0]  held_idx;

    initial begin
        n_checks = 0;
        n_err    = 0;
        src_const = 64'hD00D_C00C_B00B_A00A;

        // Owner 0 -> dwell -> 1 -> 3 -> 0, then owner drop, empty, single requester, saturation.
        tbl[0]  = '{1'b1, 4'b1011, 4'b0001, 3'd0, 1'b1};
        tbl[1]  = '{1'b0, 4'b1011, 4'b0001, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 4'b1011, 4'b0001, 3'd0, 1'b0};
        tbl[3]  = '{1'b1, 4'b1011, 4'b0001, 3'd0, 1'b0};
        tbl[4]  = '{1'b1, 4'b1011, 4'b0010, 3'd1, 1'b1};
        tbl[5]  = '{1'b1, 4'b1011, 4'b0010, 3'd1, 1'b0};
        tbl[6]  = '{1'b1, 4'b1011, 4'b0010, 3'd1, 1'b0};
        tbl[7]  = '{1'b1, 4'b1011, 4'b1000, 3'd3, 1'b1};
        tbl[8]  = '{1'b1, 4'b1011, 4'b1000, 3'd3, 1'b0};
        tbl[9]  = '{1'b1, 4'b1011, 4'b1000, 3'd3, 1'b0};
        tbl[10] = '{1'b1, 4'b1011, 4'b0001, 3'd0, 1'b1};
        tbl[11] = '{1'b1, 4'b1011, 4'b0001, 3'd0, 1'b0};
        tbl[12] = '{1'b1, 4'b1011, 4'b0001, 3'd0, 1'b0};
        tbl[13] = '{1'b1, 4'b1011, 4'b0010, 3'd1, 1'b1};
        tbl[14] = '{1'b1, 4'b1011, 4'b0010, 3'd1, 1'b0};
        tbl[15] = '{1'b0, 4'b0001, 4'b0010, 3'd1, 1'b0};
        tbl[16] = '{1'b0, 4'b0001, 4'b0010, 3'd1, 1'b0};
        tbl[17] = '{1'b1, 4'b0001, 4'b0001, 3'd0, 1'b1};
        tbl[18] = '{1'b0, 4'b0000, 4'b0001, 3'd0, 1'b0};
        tbl[19] = '{1'b1, 4'b0000, 4'b0000, 3'd0, 1'b1};
        tbl[20] = '{1'b0, 4'b0100, 4'b0000, 3'd0, 1'b0};
        tbl[21] = '{1'b1, 4'b0100, 4'b0100, 3'd2, 1'b1};
        tbl[22] = '{1'b0, 4'b0100, 4'b0100, 3'd2, 1'b0};
        tbl[23] = '{1'b1, 4'b0100, 4'b0100, 3'd2, 1'b0};
        tbl[24] = '{1'b1, 4'b0100, 4'b0100, 3'd2, 1'b0};
        tbl[25] = '{1'b1, 4'b0100, 4'b0100, 3'd2, 1'b0};

        rst             = 1'b1;
        bus.frame_begin = 1'b0;
        bus.req         = 4'd0;
        bus.src_data    = src_const;
        model_reset();
        #1;
        chk("reset_grant", 32'(bus.grant), 32'd0);
        chk("reset_idx", 32'(bus.active_idx), 32'd0);
        chk("reset_switch", 32'(bus.switch_pulse), 32'd0);
        chk("reset_pixel", 32'(bus.pixel_data), 32'(BG));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 26; v++) begin
            apply(tbl[v].fb, tbl[v].req, src_const);
            exp_pix = (tbl[v].g == 4'd0) ? BG : src_const[16*tbl[v].idx +: 16];
            chk($sformatf("vec%0d_grant", v), 32'(bus.grant), 32'(tbl[v].g));
            chk($sformatf("vec%0d_idx", v), 32'(bus.active_idx), 32'(tbl[v].idx));
            chk($sformatf("vec%0d_switch", v), 32'(bus.switch_pulse), 32'(tbl[v].sw));
            chk($sformatf("vec%0d_pixel", v), 32'(bus.pixel_data), 32'(exp_pix));
        end

        // Asynchronous reset between clock edges while owner 2 is active.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_grant", 32'(bus.grant), 32'd0);
        chk("async_rst_idx", 32'(bus.active_idx), 32'd0);
        chk("async_rst_pixel", 32'(bus.pixel_data), 32'(BG));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 4'b1000, src_const);
            chk("post_rst_nogrant", 32'(bus.grant), 32'd0);
        end
        apply(1'b1, 4'b1000, src_const);
        chk("post_rst_grant", 32'(bus.grant), 32'b1000);
        chk("post_rst_idx", 32'(bus.active_idx), 32'd3);
        chk("post_rst_switch", 32'(bus.switch_pulse), 32'd1);
        chk("post_rst_pixel", 32'(bus.pixel_data), 32'(src_const[63:48]));

        // Requests toggle for 100 cycles with no frame_begin: grant must freeze.
        held_grant = bus.grant;
        held_idx   = bus.active_idx;
        for (int c = 0; c < 100; c++) begin
            apply(1'b0, 4'($urandom), {$urandom, $urandom});
            chk("freeze_grant", 32'(bus.grant), 32'(held_grant));
            chk("freeze_idx", 32'(bus.active_idx), 32'(held_idx));
            chk("freeze_switch", 32'(bus.switch_pulse), 32'd0);
            chk("freeze_pixel", 32'(bus.pixel_data), 32'(m_pix));
        end

        // Random traffic with frequent (sometimes back-to-back) frame_begin.
        for (int c = 0; c < 600; c++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            apply(($urandom_range(0, 2) == 0), r, {$urandom, $urandom});
            chk("rand_grant", 32'(bus.grant), 32'(m_grant()));
            chk("rand_idx", 32'(bus.active_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
            chk("rand_switch", 32'(bus.switch_pulse), 32'(m_sw));
            chk("rand_pixel", 32'(bus.pixel_data), 32'(m_pix));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
